acum4: RTL and testbench
========================

# acum4

Registered 4-bit two's-complement accumulator that sits directly downstream of `sumcomp4` and wraps it.
- Accepts one signed operand per transaction over a valid/ready handshake.
- Adds the operand to the running total using a `sumcomp4` instance, or loads it when `in_clr` is set.
- Presents the result with per-operation and sticky signed-overflow flags on a second valid/ready handshake.
- Serves as the sequential result stage that consumes `sumcomp4`'s S0..S3 outputs.

## Interface
Parameters:
- `CNT_W`, 4: width of the saturating operation counter.

Ports:
- `clk`  in  1  rising-edge clock; one clock domain.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  operand available.
- `in_ready`  out  1  block can accept an operand.
- `in_data`  in  4  signed operand, two's complement, bit 3 = sign.
- `in_clr`  in  1  with the operand: load it (total = 0 + in_data) instead of accumulating.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer accepts the result.
- `out_sum`  out  4  accumulator value after the operation.
- `out_ovf`  out  1  signed overflow on this operation.
- `out_ovf_sticky`  out  1  OR of `out_ovf` since the last clear.
- `out_cnt`  out  CNT_W  operations since the last clear, including the clearing one; saturates at all-ones.

## Operation
FSM with three states: IDLE, ADD, OUT.

- **IDLE**
  - `in_ready`=1, `out_valid`=0.
  - On `in_valid`&`in_ready`: capture `in_data` into B and `in_clr` into C, then go to ADD.
- **ADD** (exactly one cycle; `in_ready`=0, `out_valid`=0)
  - Adder inputs: x = C ? 0000 : A, y = B.
  - Register A <= S.
  - ovf <= (x[3]==y[3]) && (S[3]!=x[3]).
  - sticky <= (C ? 0 : sticky) | ovf_now.
  - cnt <= C ? 1 : (cnt==max ? max : cnt+1).
  - Go to OUT.
- **OUT**
  - `out_valid`=1; `out_sum`=A, `out_ovf`, `out_ovf_sticky`, `out_cnt` held stable.
  - On `out_ready`: go to IDLE.
  - `in_ready`=0 throughout OUT; no operand is accepted in the hand-off cycle.

Arithmetic rules:
- Sum is modulo 16; the carry out of bit 3 is discarded.
- Overflow is defined only by the signed rule above.

## Timing
- Reset (asynchronous assert, synchronous deassert at the top level):
  - State = IDLE.
  - A, B, C, ovf, sticky, cnt = 0.
  - Outputs: `in_ready`=1, `out_valid`=0, `out_sum`=0000, `out_ovf`=0, `out_ovf_sticky`=0, `out_cnt`=0.
- Accept edge k → ADD during cycle k+1 → `out_valid`=1 from edge k+2.
- Minimum 3 cycles per operation when `out_ready` is held high.
- All outputs are registers or direct decodes of the state register; `in_data` has no combinational path to any output.
- `out_valid`, once asserted, stays asserted with stable data until `out_ready` is sampled high (backpressure of any length).
- `in_valid` while not in IDLE is ignored; the operand is not captured.
- Reset asserted mid-operation (ADD or OUT) immediately returns every register to its reset value; the pending result is lost.
- `in_clr` on the very first operation after reset behaves identically to a plain add, because A=0.

## Structure
- Shared package `acum4_pkg`:
  - state encoding constants IDLE=2'd0, ADD=2'd1, OUT=2'd2; encoding 2'd3 recovers to IDLE;
  - DATA_W=4;
  - overflow helper function (sign-compare rule).
- One sub-module: the existing `sumcomp4`.
  - x0..x3 driven by the muxed accumulator, y0..y3 by B, S0..S3 feeding the A register.
  - No adder logic is duplicated in `acum4`.
- FSM, operand/result registers and counter live in `acum4` itself.

## Test plan
- **Reset:** hold `rst_n`=0 for 3 cycles, then release → `in_ready`=1, `out_valid`=0, `out_sum`=0000, `out_ovf`=0, `out_ovf_sticky`=0, `out_cnt`=0.
- **Load then cancel:**
  - clr+0101 → `out_sum`=0101, `out_ovf`=0, `out_cnt`=1.
  - add 1011 → `out_sum`=0000, `out_ovf`=0, `out_cnt`=2.
- **Positive overflow, then negative overflow:**
  - clr+0111, add 0001 → `out_sum`=1000, `out_ovf`=1, `out_ovf_sticky`=1.
  - add 1111 → `out_sum`=0111, `out_ovf`=1.
  - add 0000 → `out_ovf`=0, `out_ovf_sticky`=1.
  - clr+0010 → `out_ovf_sticky`=0.
- **Backpressure:**
  - Hold `out_ready`=0 for 5 cycles after `out_valid` rises → `out_sum`/flags stable, `in_ready`=0.
  - Pulse `in_valid` with 0011 during the stall → operand ignored, and the next result is unaffected.
- **Counter saturation:** clr+0000, then 16 adds of 0000 → `out_cnt` reaches 1111 after the 14th add and stays at 1111.
- **Reset mid-op:** drop `rst_n` during the ADD cycle of clr+0110 → outputs return to reset values immediately, and the next accepted operand starts from A=0.

Source files
------------

// File: rtl/acum4_pkg.sv
// acum4_pkg: shared types, widths and the signed-overflow rule for acum4.
package acum4_pkg;

    localparam int DATA_W = 4;

    // Encoding 2'd3 is unused and is steered back to IDLE by the FSM.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        OUT  = 2'd2,
        BAD  = 2'd3
    } state_t;

    // Two's-complement overflow: operands share a sign that the result lacks.
    function automatic logic ovf_chk(
        input logic [DATA_W-1:0] x,
        input logic [DATA_W-1:0] y,
        input logic [DATA_W-1:0] s
    );
        return (x[DATA_W-1] == y[DATA_W-1]) && (s[DATA_W-1] != x[DATA_W-1]);
    endfunction

endpackage

// File: rtl/sumcomp4.sv
// sumcomp4: 4-bit ripple-carry adder, S = x + y modulo 16 (carry out dropped).
// Ports: x0..x3, y0..y3 operand bits (bit 0 = LSB); S0..S3 sum bits.
module sumcomp4 (
    input  logic x0,
    input  logic x1,
    input  logic x2,
    input  logic x3,
    input  logic y0,
    input  logic y1,
    input  logic y2,
    input  logic y3,
    output logic S0,
    output logic S1,
    output logic S2,
    output logic S3
);

    logic c1, c2, c3;

    assign S0 = x0 ^ y0;
    assign c1 = x0 & y0;
    assign S1 = x1 ^ y1 ^ c1;
    assign c2 = (x1 & y1) | (c1 & (x1 ^ y1));
    assign S2 = x2 ^ y2 ^ c2;
    assign c3 = (x2 & y2) | (c2 & (x2 ^ y2));
    assign S3 = x3 ^ y3 ^ c3;

endmodule

// File: rtl/acum4.sv
// acum4: registered 4-bit signed accumulator around sumcomp4 with valid/ready in and out.
// Ports: clk, rst_n (async active-low); in_valid/in_ready/in_data/in_clr operand side;
//        out_valid/out_ready/out_sum/out_ovf/out_ovf_sticky/out_cnt result side.
module acum4
    import acum4_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_clr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_sum,
    output logic              out_ovf,
    output logic              out_ovf_sticky,
    output logic [CNT_W-1:0]  out_cnt
);

    state_t            state;
    logic [DATA_W-1:0] a, b, x, s;
    logic              c, ovf, sticky, ovf_now;
    logic [CNT_W-1:0]  cnt;

    // A clearing operation adds the operand to zero instead of the running total.
    assign x       = c ? '0 : a;
    assign ovf_now = ovf_chk(x, b, s);

    sumcomp4 u_add (
        .x0(x[0]), .x1(x[1]), .x2(x[2]), .x3(x[3]),
        .y0(b[0]), .y1(b[1]), .y2(b[2]), .y3(b[3]),
        .S0(s[0]), .S1(s[1]), .S2(s[2]), .S3(s[3])
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a      <= '0;
            b      <= '0;
            c      <= 1'b0;
            ovf    <= 1'b0;
            sticky <= 1'b0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    b     <= in_data;
                    c     <= in_clr;
                    state <= ADD;
                end
                ADD: begin
                    a      <= s;
                    ovf    <= ovf_now;
                    sticky <= (c ? 1'b0 : sticky) | ovf_now;
                    cnt    <= c ? CNT_W'(1) : (&cnt ? cnt : cnt + CNT_W'(1));
                    state  <= OUT;
                end
                OUT: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready       = state == IDLE;
    assign out_valid      = state == OUT;
    assign out_sum        = a;
    assign out_ovf        = ovf;
    assign out_ovf_sticky = sticky;
    assign out_cnt        = cnt;

endmodule

// File: tb/tb_acum4.sv
// tb_acum4: scoreboard-driven self-checking bench for acum4.
module tb_acum4;

    typedef struct packed {
        logic [3:0] sum;
        logic       ovf;
        logic       st;
        logic [3:0] cnt;
    } res_t;

    logic       clk = 0;
    logic       rst_n = 0;
    logic       in_valid = 0;
    logic       in_ready;
    logic [3:0] in_data = 0;
    logic       in_clr = 0;
    logic       out_valid;
    logic       out_ready = 0;
    logic [3:0] out_sum;
    logic       out_ovf;
    logic       out_ovf_sticky;
    logic [3:0] out_cnt;

    int checks = 0;
    int passes = 0;

    res_t sb[$];
    logic [3:0] ma = 0;
    logic       ms = 0;
    logic [3:0] mc = 0;

    always #5 clk = ~clk;

    acum4 #(.CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_clr(in_clr),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_ovf(out_ovf), .out_ovf_sticky(out_ovf_sticky), .out_cnt(out_cnt)
    );

    function automatic res_t model(input logic [3:0] d, input logic clr);
        logic [3:0] x, s;
        logic o;
        x  = clr ? 4'd0 : ma;
        s  = x + d;
        o  = (x[3] == d[3]) && (s[3] != x[3]);
        ma = s;
        ms = (clr ? 1'b0 : ms) | o;
        mc = clr ? 4'd1 : (mc == 4'hf ? 4'hf : mc + 4'd1);
        return '{sum: s, ovf: o, st: ms, cnt: mc};
    endfunction

    task automatic do_op(input logic [3:0] d, input logic clr, input int stall, input bit poke);
        res_t e, got;
        int lat;
        sb.push_back(model(d, clr));
        @(negedge clk);
        in_valid = 1; in_data = d; in_clr = clr;
        @(posedge clk); #1;
        in_valid = 0; in_data = 0; in_clr = 0;
        lat = 0;
        while (!out_valid && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        e = sb.pop_front();
        checks++;
        if (lat !== 2) $display("FAIL latency: got %0d cycles, want 2", lat);
        else passes++;
        got = {out_sum, out_ovf, out_ovf_sticky, out_cnt};
        checks++;
        if (got !== e) $display("FAIL result: got sum=%b ovf=%b st=%b cnt=%0d, want sum=%b ovf=%b st=%b cnt=%0d",
                                got.sum, got.ovf, got.st, got.cnt, e.sum, e.ovf, e.st, e.cnt);
        else passes++;
        for (int i = 0; i < stall; i++) begin
            if (poke && i == 1) begin in_valid = 1; in_data = 4'b0011; end
            @(negedge clk);
            in_valid = 0; in_data = 0;
            got = {out_sum, out_ovf, out_ovf_sticky, out_cnt};
            checks++;
            if (got !== e || out_valid !== 1'b1 || in_ready !== 1'b0)
                $display("FAIL stall%0d: got sum=%b ovf=%b st=%b cnt=%0d v=%b r=%b, want sum=%b ovf=%b st=%b cnt=%0d v=1 r=0",
                         i, got.sum, got.ovf, got.st, got.cnt, out_valid, in_ready, e.sum, e.ovf, e.st, e.cnt);
            else passes++;
        end
        out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;
    endtask

    task automatic chk_out(input string name, input logic [3:0] s, input logic o, input logic st, input logic [3:0] c);
        checks++;
        if ({out_sum, out_ovf, out_ovf_sticky, out_cnt} !== {s, o, st, c})
            $display("FAIL %s: got sum=%b ovf=%b st=%b cnt=%0d, want sum=%b ovf=%b st=%b cnt=%0d",
                     name, out_sum, out_ovf, out_ovf_sticky, out_cnt, s, o, st, c);
        else passes++;
    endtask

    task automatic test_reset();
        rst_n = 0;
        repeat (3) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        checks++;
        if ({in_ready, out_valid, out_sum, out_ovf, out_ovf_sticky, out_cnt} !== {1'b1, 1'b0, 4'b0, 1'b0, 1'b0, 4'b0})
            $display("FAIL reset: got rdy=%b v=%b sum=%b ovf=%b st=%b cnt=%0d, want rdy=1 v=0 all zero",
                     in_ready, out_valid, out_sum, out_ovf, out_ovf_sticky, out_cnt);
        else passes++;
    endtask

    task automatic test_load_cancel();
        do_op(4'b0101, 1, 0, 0); chk_out("load", 4'b0101, 0, 0, 4'd1);
        do_op(4'b1011, 0, 0, 0); chk_out("cancel", 4'b0000, 0, 0, 4'd2);
    endtask

    task automatic test_overflow();
        do_op(4'b0111, 1, 0, 0);
        do_op(4'b0001, 0, 0, 0); chk_out("pos_ovf", 4'b1000, 1, 1, 4'd2);
        do_op(4'b1111, 0, 0, 0); chk_out("neg_ovf", 4'b0111, 1, 1, 4'd3);
        do_op(4'b0000, 0, 0, 0); chk_out("sticky_hold", 4'b0111, 0, 1, 4'd4);
        do_op(4'b0010, 1, 0, 0); chk_out("sticky_clr", 4'b0010, 0, 0, 4'd1);
    endtask

    task automatic test_backpressure();
        do_op(4'b0100, 0, 5, 1); chk_out("bp_result", 4'b0110, 0, 0, 4'd2);
        do_op(4'b0001, 0, 0, 0); chk_out("bp_after", 4'b0111, 0, 0, 4'd3);
    endtask

    task automatic test_saturation();
        do_op(4'b0000, 1, 0, 0);
        for (int i = 1; i <= 16; i++) begin
            do_op(4'b0000, 0, 0, 0);
            if (i == 13) chk_out("sat_13", 4'b0000, 0, 0, 4'd14);
            if (i == 14) chk_out("sat_14", 4'b0000, 0, 0, 4'd15);
        end
        chk_out("sat_16", 4'b0000, 0, 0, 4'd15);
    endtask

    task automatic test_reset_midop();
        do_op(4'b0101, 1, 0, 0);
        @(negedge clk);
        in_valid = 1; in_data = 4'b0110; in_clr = 1;
        @(posedge clk); #1;
        in_valid = 0; in_data = 0; in_clr = 0;
        #2 rst_n = 0;
        #1;
        checks++;
        if ({in_ready, out_valid, out_sum, out_ovf, out_ovf_sticky, out_cnt} !== {1'b1, 1'b0, 4'b0, 1'b0, 1'b0, 4'b0})
            $display("FAIL midop_reset: got rdy=%b v=%b sum=%b ovf=%b st=%b cnt=%0d, want rdy=1 v=0 all zero",
                     in_ready, out_valid, out_sum, out_ovf, out_ovf_sticky, out_cnt);
        else passes++;
        ma = 0; ms = 0; mc = 0;
        @(negedge clk);
        rst_n = 1;
        do_op(4'b0011, 0, 0, 0); chk_out("after_reset", 4'b0011, 0, 0, 4'd1);
    endtask

    initial begin
        test_reset();
        test_load_cancel();
        test_overflow();
        test_backpressure();
        test_saturation();
        test_reset_midop();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
